traffic_phase_ctrl: RTL and testbench

Controller for a two-road intersection with one pedestrian crossing. It is the requesting side of the `timer` start/length/done/flicker interface. It loads a phase length and pulses `t_start`, then advances its phase state machine when `t_done` returns. It drives both road lights and the walk signal, and uses `t_flicker` to blink the walk lamp at the end of a walk phase.

---
 rtl/traffic_phase_ctrl.sv | 150 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Phase controller for a two-road intersection with one pedestrian crossing.
// It programs an external timer with a phase length and a one-cycle start
// pulse, then steps through the phase sequence each time the timer reports
// that the programmed length has elapsed.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   ew_car     - car waiting on the EW road (level)
//   ped_btn    - pedestrian request (level)
//   t_done     - timer: programmed length elapsed
//   t_flicker  - timer: final ticks of the current length
//   t_start    - timer: one-cycle start pulse, first cycle of each phase
//   t_length   - timer: phase length, held between start pulses
//   ns_light   - NS road lamps {red,yellow,green}, one-hot
//   ew_light   - EW road lamps {red,yellow,green}, one-hot
//   walk       - walk lamp
//   walk_flash - walk lamp blink enable
module traffic_phase_ctrl #(
   parameter int GREEN_LEN  = 20,
   parameter int YELLOW_LEN = 5,
   parameter int CLEAR_LEN  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ew_car,
   input  logic       ped_btn,
   input  logic       t_done,
   input  logic       t_flicker,
   output logic       t_start,
   output logic [4:0] t_length,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic       walk_flash
);

   localparam logic [4:0] GREEN_L  = 5'(GREEN_LEN);
   localparam logic [4:0] YELLOW_L = 5'(YELLOW_LEN);
   localparam logic [4:0] CLEAR_L  = 5'(CLEAR_LEN);

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   typedef enum logic [2:0] {
      CLR_TO_NS,
      NS_GREEN,
      NS_YELLOW,
      CLR_TO_EW,
      EW_GREEN,
      EW_YELLOW
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       need_start;
   logic       ped_pending;
   logic       advance;
   logic [4:0] next_len;
   logic [2:0] next_ns;
   logic [2:0] next_ew;

   // The timer's done flag still reflects the previous phase during the
   // start-pulse cycle, so it only counts when no pulse is being issued.
   assign advance = t_done & ~t_start;

   // The blink follows the timer's flicker window but never during the
   // start cycle, where t_flicker is stale from the phase just left.
   assign walk_flash = walk & t_flicker & ~t_start;

   // Phase sequencing: work out where a qualified done would take us, and
   // the timer length plus lamp pattern belonging to that destination.
   always_comb begin
      next_state = state;
      next_len   = CLEAR_L;
      next_ns    = LAMP_RED;
      next_ew    = LAMP_RED;
      case (state)
         CLR_TO_NS: next_state = NS_GREEN;
         NS_GREEN:  next_state = (ew_car | ped_pending) ? NS_YELLOW : NS_GREEN;
         NS_YELLOW: next_state = CLR_TO_EW;
         CLR_TO_EW: next_state = EW_GREEN;
         EW_GREEN:  next_state = EW_YELLOW;
         EW_YELLOW: next_state = CLR_TO_NS;
         default:   next_state = CLR_TO_NS;
      endcase
      case (next_state)
         NS_GREEN: begin
            next_len = GREEN_L;
            next_ns  = LAMP_GREEN;
         end
         NS_YELLOW: begin
            next_len = YELLOW_L;
            next_ns  = LAMP_YELLOW;
         end
         EW_GREEN: begin
            next_len = GREEN_L;
            next_ew  = LAMP_GREEN;
         end
         EW_YELLOW: begin
            next_len = YELLOW_L;
            next_ew  = LAMP_YELLOW;
         end
         default: next_len = CLEAR_L;
      endcase
   end

   // Registered state and outputs. need_start makes the first cycle out of
   // reset behave like an entry into CLR_TO_NS so the timer gets programmed.
   // The pedestrian request latches until the EW green it is served by; a
   // press arriving on that same edge survives for the next cycle round.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= CLR_TO_NS;
         need_start  <= 1'b1;
         ped_pending <= 1'b0;
         t_start     <= 1'b0;
         t_length    <= 5'd0;
         ns_light    <= LAMP_RED;
         ew_light    <= LAMP_RED;
         walk        <= 1'b0;
      end else begin
         t_start <= 1'b0;
         if (need_start) begin
            need_start  <= 1'b0;
            t_start     <= 1'b1;
            t_length    <= CLEAR_L;
            ped_pending <= ped_pending | ped_btn;
         end else if (advance) begin
            state    <= next_state;
            t_start  <= 1'b1;
            t_length <= next_len;
            ns_light <= next_ns;
            ew_light <= next_ew;
            if (next_state == EW_GREEN) begin
               walk        <= ped_pending;
               ped_pending <= ped_btn;
            end else begin
               walk        <= 1'b0;
               ped_pending <= ped_pending | ped_btn;
            end
         end else begin
            ped_pending <= ped_pending | ped_btn;
         end
      end
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
// Bench for traffic_phase_ctrl: directed phase walks with literal
// expectations, then randomized inputs, all compared every cycle against a
// table-driven model of the phase cycle.
module tb_traffic_phase_ctrl;

   localparam int GREEN_LEN  = 20;
   localparam int YELLOW_LEN = 5;
   localparam int CLEAR_LEN  = 2;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       ew_car    = 1'b0;
   logic       ped_btn   = 1'b0;
   logic       t_done    = 1'b0;
   logic       t_flicker = 1'b0;
   logic       t_start;
   logic [4:0] t_length;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic       walk_flash;

   int tests_run  = 0;
   int tests_fail = 0;
   logic check_en = 1'b0;

   traffic_phase_ctrl #(
      .GREEN_LEN (GREEN_LEN),
      .YELLOW_LEN(YELLOW_LEN),
      .CLEAR_LEN (CLEAR_LEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ew_car    (ew_car),
      .ped_btn   (ped_btn),
      .t_done    (t_done),
      .t_flicker (t_flicker),
      .t_start   (t_start),
      .t_length  (t_length),
      .ns_light  (ns_light),
      .ew_light  (ew_light),
      .walk      (walk),
      .walk_flash(walk_flash)
   );

   always #5 clk = ~clk;

   // Phase cycle as tables indexed by position 0..5:
   // clear-to-NS, NS green, NS yellow, clear-to-EW, EW green, EW yellow.
   int         phase_len [6] = '{CLEAR_LEN, GREEN_LEN, YELLOW_LEN, CLEAR_LEN, GREEN_LEN, YELLOW_LEN};
   logic [2:0] phase_ns  [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
   logic [2:0] phase_ew  [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};

   int   m_phase;
   logic m_need;
   logic m_start;
   int   m_len;
   logic m_walk;
   logic m_ped;

   // Model: one step per clock, advancing the phase position on a done that
   // is not sitting in a start-pulse cycle.
   always @(posedge clk or posedge reset) begin : model
      int  np;
      bit  adv;
      if (reset) begin
         m_phase <= 0;
         m_need  <= 1'b1;
         m_start <= 1'b0;
         m_len   <= 0;
         m_walk  <= 1'b0;
         m_ped   <= 1'b0;
      end else begin
         adv = !m_need && t_done && !m_start;
         np  = m_phase;
         if (adv) begin
            if (m_phase == 1 && !(ew_car || m_ped)) np = 1;
            else np = (m_phase + 1) % 6;
         end
         m_need  <= 1'b0;
         m_start <= m_need || adv;
         if (m_need || adv) m_len <= phase_len[np];
         if (adv) m_walk <= (np == 4) ? m_ped : 1'b0;
         m_ped   <= (adv && np == 4) ? ped_btn : (m_ped || ped_btn);
         m_phase <= np;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_fail++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, sampled mid-low-phase.
   always @(negedge clk) begin
      #1;
      if (check_en) begin
         check("model t_start",    8'(t_start),    8'(m_start));
         check("model t_length",   8'(t_length),   8'(m_len));
         check("model ns_light",   8'(ns_light),   8'(phase_ns[m_phase]));
         check("model ew_light",   8'(ew_light),   8'(phase_ew[m_phase]));
         check("model walk",       8'(walk),       8'(m_walk));
         check("model walk_flash", 8'(walk_flash), 8'(m_walk & t_flicker & ~m_start));
      end
   end

   task automatic applyStimulus_pulse_done();
      @(negedge clk);
      t_done = 1'b1;
      @(negedge clk);
      t_done = 1'b0;
      #1;
   endtask

   task automatic applyStimulus_ped();
      @(negedge clk);
      ped_btn = 1'b1;
      @(negedge clk);
      ped_btn = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                              input logic st, input logic [4:0] len, input logic wk);
      check({tag, " ns"},      8'(ns_light), 8'(ns));
      check({tag, " ew"},      8'(ew_light), 8'(ew));
      check({tag, " t_start"}, 8'(t_start),  8'(st));
      check({tag, " t_length"},8'(t_length), 8'(len));
      check({tag, " walk"},    8'(walk),     8'(wk));
   endtask

   initial begin
      int pulses;
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      #1;
      checkOutput("in reset", 3'b100, 3'b100, 1'b0, 5'd0, 1'b0);
      #1 reset = 1'b0;

      // Startup pulse programs the clearance length.
      @(negedge clk); #1;
      checkOutput("startup", 3'b100, 3'b100, 1'b1, 5'd2, 1'b0);
      @(negedge clk); #1;
      checkOutput("startup idle", 3'b100, 3'b100, 1'b0, 5'd2, 1'b0);

      // No demand: NS green rests and re-pulses.
      applyStimulus_pulse_done();
      checkOutput("ns green", 3'b001, 3'b100, 1'b1, 5'd20, 1'b0);
      applyStimulus_pulse_done();
      checkOutput("ns rest", 3'b001, 3'b100, 1'b1, 5'd20, 1'b0);

      // Car demand: full cycle back to clear-to-NS.
      ew_car = 1'b1;
      applyStimulus_pulse_done();
      checkOutput("ns yellow", 3'b010, 3'b100, 1'b1, 5'd5, 1'b0);
      applyStimulus_pulse_done();
      checkOutput("clr ew", 3'b100, 3'b100, 1'b1, 5'd2, 1'b0);
      applyStimulus_pulse_done();
      checkOutput("ew green car", 3'b100, 3'b001, 1'b1, 5'd20, 1'b0);
      applyStimulus_pulse_done();
      checkOutput("ew yellow", 3'b100, 3'b010, 1'b1, 5'd5, 1'b0);
      applyStimulus_pulse_done();
      checkOutput("clr ns", 3'b100, 3'b100, 1'b1, 5'd2, 1'b0);
      ew_car = 1'b0;

      // Pedestrian demand alone ends NS green and lights walk.
      applyStimulus_pulse_done();
      applyStimulus_ped();
      applyStimulus_pulse_done();
      checkOutput("ped ns yellow", 3'b010, 3'b100, 1'b1, 5'd5, 1'b0);
      applyStimulus_pulse_done();
      t_flicker = 1'b1;
      applyStimulus_pulse_done();
      checkOutput("ped ew green", 3'b100, 3'b001, 1'b1, 5'd20, 1'b1);
      check("flash in start cycle", 8'(walk_flash), 8'd0);
      @(negedge clk); #1;
      check("flash on flicker", 8'(walk_flash), 8'd1);
      t_flicker = 1'b0;
      #1 check("flash off", 8'(walk_flash), 8'd0);

      // Request was consumed: NS green rests again afterwards.
      applyStimulus_pulse_done();
      checkOutput("ped ew yellow", 3'b100, 3'b010, 1'b1, 5'd5, 1'b0);
      applyStimulus_pulse_done();
      applyStimulus_pulse_done();
      applyStimulus_pulse_done();
      checkOutput("ped cleared rest", 3'b001, 3'b100, 1'b1, 5'd20, 1'b0);

      // Back to a walking EW green, then reset in the middle of it.
      applyStimulus_ped();
      applyStimulus_pulse_done();
      applyStimulus_pulse_done();
      applyStimulus_pulse_done();
      checkOutput("walk again", 3'b100, 3'b001, 1'b1, 5'd20, 1'b1);
      @(negedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("async reset", 3'b100, 3'b100, 1'b0, 5'd0, 1'b0);
      check("async reset flash", 8'(walk_flash), 8'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk); #1;
      checkOutput("post reset", 3'b100, 3'b100, 1'b1, 5'd2, 1'b0);

      // Held done: every other cycle is a start pulse, never two in a row.
      ew_car = 1'b1;
      @(negedge clk);
      t_done = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(negedge clk); #1;
         pulses += int'(t_start);
      end
      t_done = 1'b0;
      check("held done pulses", 8'(pulses), 8'd6);

      // Randomized run with occasional resets.
      repeat (3000) begin
         @(negedge clk);
         if (reset) reset = 1'b0;
         else if ($urandom_range(299) == 0) reset = 1'b1;
         t_done    = ($urandom_range(3) == 0);
         ew_car    = ($urandom_range(1) == 0);
         ped_btn   = ($urandom_range(9) == 0);
         t_flicker = ($urandom_range(2) == 0);
      end
      @(negedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule
